// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the local predictor bank
package bp_pkg;

    // 2-bit saturating counter encoding; the MSB is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } counter_t;

    // PC bits used as the table index (table has 2**INDEX_WIDTH entries)
    localparam int DEFAULT_INDEX_WIDTH = 6;

    // One counter per 2-bit global history pattern
    localparam int PATTERNS = 4;

endpackage

// File: rtl/local_predictor_bank_if.sv
// rtl/local_predictor_bank_if.sv - fetch prediction and execute training signals
interface local_predictor_bank_if;

    // Fetch-side lookup
    logic [31:0] pc_f_i;
    logic [1:0]  local_src_f_i;
    logic        predict_taken_f_o;

    // Execute-side training
    logic        stall_ex_i;
    logic [1:0]  branch_op_ex_i;
    logic        pc_src_res_ex_i;
    logic [31:0] pc_ex_i;
    logic [1:0]  local_src_ex_i;

    // Pipeline side: drives lookups and resolved branches
    modport master (
        output pc_f_i,
        output local_src_f_i,
        input  predict_taken_f_o,
        output stall_ex_i,
        output branch_op_ex_i,
        output pc_src_res_ex_i,
        output pc_ex_i,
        output local_src_ex_i
    );

    // Predictor side
    modport slave (
        input  pc_f_i,
        input  local_src_f_i,
        output predict_taken_f_o,
        input  stall_ex_i,
        input  branch_op_ex_i,
        input  pc_src_res_ex_i,
        input  pc_ex_i,
        input  local_src_ex_i
    );

endinterface

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - single 2-bit saturating direction counter
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter counter_t RESET_VAL = WNT
) (
    input  logic     clk_i,
    input  logic     reset_n_i,
    input  logic     en_i,
    input  logic     taken_i,
    output counter_t state_o
);

    counter_t state_q;
    counter_t state_d;

    // Step toward taken or untaken when enabled, sticking at the ends
    always_comb begin
        state_d = state_q;
        if (en_i) begin
            if (taken_i) begin
                case (state_q)
                    SNT:     state_d = WNT;
                    WNT:     state_d = WT;
                    WT:      state_d = ST;
                    default: state_d = ST;
                endcase
            end else begin
                case (state_q)
                    ST:      state_d = WT;
                    WT:      state_d = WNT;
                    WNT:     state_d = SNT;
                    default: state_d = SNT;
                endcase
            end
        end
    end

    // Counter state register, cleared to the reset value asynchronously
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/local_predictor_bank.sv
// rtl/local_predictor_bank.sv - PC-indexed table of per-history 2-bit counters
module local_predictor_bank
    import bp_pkg::*;
#(
    parameter int       INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter counter_t RESET_STATE = WNT
) (
    input logic             clk_i,
    input logic             reset_n_i,
    local_predictor_bank_if.slave bp
);

    localparam int ENTRIES = 2 ** INDEX_WIDTH;
    localparam int COUNTERS = ENTRIES * PATTERNS;

    logic [INDEX_WIDTH-1:0] rd_idx;
    logic [INDEX_WIDTH-1:0] wr_idx;
    logic                   upd;
    logic [COUNTERS-1:0]    we;
    logic [1:0]             cnt [ENTRIES][PATTERNS];
    logic                   unused_bits;

    // Word-aligned index decode; low byte-offset bits and high PC bits are dropped
    always_comb begin
        rd_idx = bp.pc_f_i[INDEX_WIDTH+1:2];
        wr_idx = bp.pc_ex_i[INDEX_WIDTH+1:2];
        upd    = bp.branch_op_ex_i[0] & ~bp.stall_ex_i;
    end

    // One-hot write enable: entry and history pattern together pick one counter
    always_comb begin
        we = '0;
        if (upd) begin
            we[{wr_idx, bp.local_src_ex_i}] = 1'b1;
        end
    end

    // Combinational lookup; reads the registered value, so no same-cycle bypass
    always_comb begin
        bp.predict_taken_f_o = cnt[rd_idx][bp.local_src_f_i][1];
    end

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        for (genvar p = 0; p < PATTERNS; p++) begin : g_pat
            bp_sat_counter #(
                .RESET_VAL (RESET_STATE)
            ) u_ctr (
                .clk_i     (clk_i),
                .reset_n_i (reset_n_i),
                .en_i      (we[e*PATTERNS+p]),
                .taken_i   (bp.pc_src_res_ex_i),
                .state_o   (cnt[e][p])
            );
        end
    end

    // PC bits outside the index and the non-conditional op bit never affect the table
    assign unused_bits = ^{bp.pc_f_i[31:INDEX_WIDTH+2], bp.pc_f_i[1:0],
                           bp.pc_ex_i[31:INDEX_WIDTH+2], bp.pc_ex_i[1:0],
                           bp.branch_op_ex_i[1]};

endmodule

// File: tb/tb_local_predictor_bank.sv
// tb/tb_local_predictor_bank.sv - directed self-checking bench for local_predictor_bank
module tb_local_predictor_bank;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    local_predictor_bank_if bp_if ();

    local_predictor_bank dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bp        (bp_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic probe(input string tag, input logic [31:0] pc, input logic [1:0] h,
                         input logic expected);
        bp_if.pc_f_i        = pc;
        bp_if.local_src_f_i = h;
        #1;
        check(tag, bp_if.predict_taken_f_o, expected);
    endtask

    task automatic train(input logic [31:0] pc, input logic [1:0] h, input logic taken,
                         input logic stall, input logic [1:0] op);
        @(negedge clk);
        bp_if.pc_ex_i         = pc;
        bp_if.local_src_ex_i  = h;
        bp_if.pc_src_res_ex_i = taken;
        bp_if.stall_ex_i      = stall;
        bp_if.branch_op_ex_i  = op;
        @(posedge clk);
        #1;
        bp_if.branch_op_ex_i  = 2'b00;
        bp_if.stall_ex_i      = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bp_if.pc_f_i          = '0;
        bp_if.local_src_f_i   = '0;
        bp_if.stall_ex_i      = 1'b0;
        bp_if.branch_op_ex_i  = 2'b00;
        bp_if.pc_src_res_ex_i = 1'b0;
        bp_if.pc_ex_i         = '0;
        bp_if.local_src_ex_i  = '0;

        // Reset sweep: every entry and pattern predicts untaken
        for (int a = 0; a < 64; a++) begin
            for (int h = 0; h < 4; h++) begin
                probe("reset_sweep", 32'(a * 4), 2'(h), 1'b0);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        probe("after_release", 32'h40, 2'b10, 1'b0);

        // Saturation up at pc 0x40, history 10
        train(32'h40, 2'b10, 1'b1, 1'b0, 2'b01);
        probe("up1_h10", 32'h40, 2'b10, 1'b1);
        probe("up1_h00", 32'h40, 2'b00, 1'b0);
        probe("up1_h01", 32'h40, 2'b01, 1'b0);
        probe("up1_h11", 32'h40, 2'b11, 1'b0);
        train(32'h40, 2'b10, 1'b1, 1'b0, 2'b01);
        probe("up2_h10", 32'h40, 2'b10, 1'b1);
        train(32'h40, 2'b10, 1'b1, 1'b0, 2'b01);
        probe("up3_h10", 32'h40, 2'b10, 1'b1);

        // Saturation down: ST->WT->WNT->SNT->SNT
        train(32'h40, 2'b10, 1'b0, 1'b0, 2'b01);
        probe("dn1_h10", 32'h40, 2'b10, 1'b1);
        train(32'h40, 2'b10, 1'b0, 1'b0, 2'b01);
        probe("dn2_h10", 32'h40, 2'b10, 1'b0);
        train(32'h40, 2'b10, 1'b0, 1'b0, 2'b01);
        probe("dn3_h10", 32'h40, 2'b10, 1'b0);
        train(32'h40, 2'b10, 1'b0, 1'b0, 2'b01);
        probe("dn4_h10", 32'h40, 2'b10, 1'b0);
        // One taken from SNT reaches only WNT, still untaken
        train(32'h40, 2'b10, 1'b1, 1'b0, 2'b01);
        probe("floor_then_up", 32'h40, 2'b10, 1'b0);

        // Gating: counter is WNT, so any leaked taken update would flip the prediction
        train(32'h40, 2'b10, 1'b1, 1'b1, 2'b01);
        probe("gate_stall", 32'h40, 2'b10, 1'b0);
        train(32'h40, 2'b10, 1'b1, 1'b0, 2'b10);
        probe("gate_op", 32'h40, 2'b10, 1'b0);

        // Read during write to the same counter: old value this cycle, new value next
        @(negedge clk);
        bp_if.pc_f_i          = 32'h10;
        bp_if.local_src_f_i   = 2'b01;
        bp_if.pc_ex_i         = 32'h10;
        bp_if.local_src_ex_i  = 2'b01;
        bp_if.pc_src_res_ex_i = 1'b1;
        bp_if.branch_op_ex_i  = 2'b01;
        #1;
        check("rdw_same_cycle", bp_if.predict_taken_f_o, 1'b0);
        @(posedge clk);
        #1;
        bp_if.branch_op_ex_i = 2'b00;
        check("rdw_next_cycle", bp_if.predict_taken_f_o, 1'b1);

        // Aliasing and ignored PC bits
        train(32'h004, 2'b11, 1'b1, 1'b0, 2'b01);
        train(32'h004, 2'b11, 1'b1, 1'b0, 2'b01);
        probe("alias_base", 32'h004, 2'b11, 1'b1);
        probe("alias_0x104", 32'h104, 2'b11, 1'b1);
        probe("alias_low_bits", 32'h007, 2'b11, 1'b1);
        probe("alias_high_bits", 32'h8000_0004, 2'b11, 1'b1);
        probe("neighbor_entry", 32'h008, 2'b11, 1'b0);
        probe("other_pattern", 32'h004, 2'b10, 1'b0);

        // Asynchronous reset pulse in the middle of a cycle
        @(posedge clk);
        #2;
        probe("pre_async_rst", 32'h104, 2'b11, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rst_0x104", bp_if.predict_taken_f_o, 1'b0);
        probe("async_rst_0x10", 32'h10, 2'b01, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        probe("post_rst_0x104", 32'h104, 2'b11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
